// File: rtl/addsub_seq.sv
// Chunk-serial add/subtract sequencer: one WIDTH-bit chunk per cycle, LSB first, carry held in a register.
// Optional signed-overflow output V is enabled by defining ADDSUB_SEQ_OVF_EN.
module addsub_seq #(
  parameter int WIDTH  = 2,
  parameter int CHUNKS = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      I_VALID,
  output logic                      I_READY,
  input  logic                      OP,
  input  logic [WIDTH*CHUNKS-1:0]   A,
  input  logic [WIDTH*CHUNKS-1:0]   B,
  output logic                      O_VALID,
  input  logic                      O_READY,
  output logic [WIDTH*CHUNKS-1:0]   O,
  output logic                      COUT
`ifdef ADDSUB_SEQ_OVF_EN
  ,
  output logic                      V
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // I_READY is high only in IDLE and O_VALID only in DONE, so requests never overlap.
  localparam int N  = WIDTH * CHUNKS;
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           op_q, op_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   res_q, res_d;
  logic           cout_q, cout_d;

  logic [WIDTH-1:0] chunk_a;
  logic [WIDTH-1:0] chunk_b;
  logic [WIDTH:0]   sum;

`ifdef ADDSUB_SEQ_OVF_EN
  logic v_q, v_d;
  logic msb_cin;
`endif

  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int k = 0; k < CHUNKS; k++) begin
      if (idx_q == IW'(k)) begin
        chunk_a = a_q[k*WIDTH +: WIDTH];
        chunk_b = b_q[k*WIDTH +: WIDTH] ^ {WIDTH{op_q}};
      end
    end
    sum = {1'b0, chunk_a} + {1'b0, chunk_b} + (WIDTH+1)'(carry_q);
  end

`ifdef ADDSUB_SEQ_OVF_EN
  // Carry into the top bit recovered from the top sum bit and its two operand bits.
  assign msb_cin = sum[WIDTH-1] ^ chunk_a[WIDTH-1] ^ chunk_b[WIDTH-1];
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
`ifdef ADDSUB_SEQ_OVF_EN
    v_d     = v_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (I_VALID) begin
          a_d     = A;
          b_d     = B;
          op_d    = OP;
          carry_d = OP;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < CHUNKS; k++) begin
          if (idx_q == IW'(k)) res_d[k*WIDTH +: WIDTH] = sum[WIDTH-1:0];
        end
        carry_d = sum[WIDTH];
        if (idx_q == LAST_IDX) begin
          cout_d  = sum[WIDTH];
`ifdef ADDSUB_SEQ_OVF_EN
          v_d     = msb_cin ^ sum[WIDTH];
`endif
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (O_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
`ifdef ADDSUB_SEQ_OVF_EN
      v_q     <= v_d;
`endif
    end
  end

  assign I_READY = (state_q == S_IDLE);
  assign O_VALID = (state_q == S_DONE);
  assign O       = res_q;
  assign COUT    = cout_q;
`ifdef ADDSUB_SEQ_OVF_EN
  assign V       = v_q;
`endif

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq (WIDTH=2, CHUNKS=4): directed cases plus random ops against an arithmetic model.
// V is checked only when ADDSUB_SEQ_OVF_EN is defined.
module tb_addsub_seq;

  localparam int WIDTH  = 2;
  localparam int CHUNKS = 4;
  localparam int N      = WIDTH * CHUNKS;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic         op = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         o_valid;
  logic         o_ready = 1'b0;
  logic [N-1:0] o;
  logic         cout;
`ifdef ADDSUB_SEQ_OVF_EN
  logic         v;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [N+1:0] exp_q[$];

  addsub_seq #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) dut (
    .CLK     (clk),
    .RESET   (reset),
    .I_VALID (i_valid),
    .I_READY (i_ready),
    .OP      (op),
    .A       (a),
    .B       (b),
    .O_VALID (o_valid),
    .O_READY (o_ready),
    .O       (o),
    .COUT    (cout)
`ifdef ADDSUB_SEQ_OVF_EN
    ,
    .V       (v)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected {v, cout, o} from plain unsigned/signed arithmetic.
  function automatic logic [N+1:0] model(input bit m_op, input logic [N-1:0] ma, input logic [N-1:0] mb);
    int ua, ub, sa, sb, r, sr;
    logic m_cout, m_v;
    logic [N-1:0] m_o;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    r  = m_op ? (ua - ub) : (ua + ub);
    sr = m_op ? (sa - sb) : (sa + sb);
    m_o    = N'(r & ((1 << N) - 1));
    m_cout = m_op ? (ua >= ub) : (r >= (1 << N));
    m_v    = (sr > (1 << (N-1)) - 1) || (sr < -(1 << (N-1)));
    return {m_v, m_cout, m_o};
  endfunction

  task automatic check_result(input string tag, input logic [N+1:0] e);
    check({tag, "_o"}, 32'(o), 32'(e[N-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(e[N]));
`ifdef ADDSUB_SEQ_OVF_EN
    check({tag, "_v"}, 32'(v), 32'(e[N+1]));
`endif
  endtask

  // Issue one request, check latency, optionally stall DONE (poking I_VALID), then consume.
  task automatic run_op(input bit t_op, input logic [N-1:0] ta, input logic [N-1:0] tb,
                        input int stall, input bit scramble);
    logic [N+1:0] e;
    int waited;
    waited = 0;
    while (!i_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("iready_before_req", 32'(i_ready), 32'd1);
    op = t_op; a = ta; b = tb; i_valid = 1'b1;
    exp_q.push_back(model(t_op, ta, tb));
    @(negedge clk);
    i_valid = 1'b0;
    check("ovalid_after_accept", 32'(o_valid), 32'd0);
    check("iready_in_run", 32'(i_ready), 32'd0);
    for (int i = 1; i <= CHUNKS; i++) begin
      if (scramble) begin
        a = N'($urandom); b = N'($urandom); op = 1'($urandom);
      end
      @(negedge clk);
      check("ovalid_latency", 32'(o_valid), 32'(i == CHUNKS));
    end
    waited = 0;
    while (!o_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("ovalid_wait", 32'(o_valid), 32'd1);
    e = exp_q.pop_front();
    for (int s = 0; s < stall; s++) begin
      i_valid = 1'b1; a = N'($urandom); b = N'($urandom); op = 1'($urandom);
      check_result("stall", e);
      check("stall_iready", 32'(i_ready), 32'd0);
      check("stall_ovalid", 32'(o_valid), 32'd1);
      @(negedge clk);
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    check_result("result", e);
    @(negedge clk);
    o_ready = 1'b0;
    check("ovalid_after_pop", 32'(o_valid), 32'd0);
    check("iready_after_pop", 32'(i_ready), 32'd1);
    check_result("idle_hold", e);
  endtask

  initial begin
    // Reset with a request pending: reset must win.
    i_valid = 1'b1; a = 8'h12; b = 8'h34;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    i_valid = 1'b0;
    check("reset_iready", 32'(i_ready), 32'd1);
    check("reset_ovalid", 32'(o_valid), 32'd0);
    check("reset_o", 32'(o), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
`ifdef ADDSUB_SEQ_OVF_EN
    check("reset_v", 32'(v), 32'd0);
`endif

    run_op(1'b0, 8'h7F, 8'h01, 0, 1'b0);
    run_op(1'b0, 8'hFF, 8'h01, 0, 1'b0);
    run_op(1'b1, 8'h05, 8'h07, 0, 1'b0);
    run_op(1'b1, 8'h80, 8'h01, 3, 1'b0);

    // Reset during the second RUN cycle of 0xAA + 0x55.
    op = 1'b0; a = 8'hAA; b = 8'h55; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrun_reset_iready", 32'(i_ready), 32'd1);
    check("midrun_reset_ovalid", 32'(o_valid), 32'd0);
    check("midrun_reset_o", 32'(o), 32'd0);
    check("midrun_reset_cout", 32'(cout), 32'd0);
    @(negedge clk);
    check("midrun_reset_still_idle", 32'(o_valid), 32'd0);

    run_op(1'b0, 8'h10, 8'h20, 0, 1'b0);
    run_op(1'b0, 8'h3C, 8'hC5, 1, 1'b1);
    run_op(1'b1, 8'h00, 8'hFF, 0, 1'b1);

    for (int n = 0; n < 24; n++) begin
      run_op(1'($urandom), N'($urandom), N'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
